// File: rtl/mac_pkg.sv
// Shared defaults and width helpers for the multiply-accumulate pipeline.
package mac_pkg;

    localparam int BW_DEF      = 8;
    localparam int PR_DEF      = 8;
    localparam int ACC_EXT_DEF = 4;

    function automatic int calc_bw_psum(input int bw, input int pr);
        return 2 * bw + $clog2(pr);
    endfunction

    function automatic int calc_bw_acc(input int bw, input int pr, input int acc_ext);
        return calc_bw_psum(bw, pr) + acc_ext;
    endfunction

endpackage

// File: rtl/mac_acc_pipe_if.sv
// Beat-in / result-out handshake bundle between a producer and mac_acc_pipe.
interface mac_acc_pipe_if
    import mac_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int pr      = PR_DEF,
    parameter int acc_ext = ACC_EXT_DEF
);
    localparam int bw_acc = calc_bw_acc(bw, pr, acc_ext);

    logic              in_valid;
    logic              in_ready;
    logic [pr*bw-1:0]  a;
    logic [pr*bw-1:0]  b;
    logic              signed_mode;
    logic              acc_first;
    logic              acc_last;
    logic [bw_acc-1:0] out;
    logic              sat;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_valid, a, b, signed_mode, acc_first, acc_last, out_ready,
        input  in_ready, out, sat, out_valid
    );

    modport slave (
        input  in_valid, a, b, signed_mode, acc_first, acc_last, out_ready,
        output in_ready, out, sat, out_valid
    );

endinterface

// File: rtl/mac_lane.sv
// One lane multiplier: operands extended to 2*bw bits by mode, low 2*bw product bits kept.
module mac_lane #(
    parameter int bw = 8
) (
    input  logic            signed_mode_i,
    input  logic [bw-1:0]   a_i,
    input  logic [bw-1:0]   b_i,
    output logic [2*bw-1:0] p_o
);

    logic [2*bw-1:0] a_ext_s;
    logic [2*bw-1:0] b_ext_s;

    // Operand extension selected by the beat's signedness.
    always_comb begin
        a_ext_s = {{bw{1'b0}}, a_i};
        b_ext_s = {{bw{1'b0}}, b_i};
        if (signed_mode_i) begin
            a_ext_s = {{bw{a_i[bw-1]}}, a_i};
            b_ext_s = {{bw{b_i[bw-1]}}, b_i};
        end else begin
            a_ext_s = {{bw{1'b0}}, a_i};
            b_ext_s = {{bw{1'b0}}, b_i};
        end
    end

    assign p_o = a_ext_s * b_ext_s;

endmodule

// File: rtl/mac_acc_pipe.sv
// Pipelined pr-lane dot product with saturating group accumulator and a
// single output register held under backpressure.
module mac_acc_pipe
    import mac_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int pr      = PR_DEF,
    parameter int acc_ext = ACC_EXT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mac_acc_pipe_if.slave bus
);

    localparam int bw_psum = calc_bw_psum(bw, pr);
    localparam int bw_acc  = calc_bw_acc(bw, pr, acc_ext);
    localparam int BW_PROD = 2 * bw;
    localparam int EXT_W   = bw_acc - BW_PROD;
    localparam logic [bw_acc-1:0] SMAX = {1'b0, {(bw_acc-1){1'b1}}};
    localparam logic [bw_acc-1:0] SMIN = {1'b1, {(bw_acc-1){1'b0}}};
    localparam logic [bw_acc-1:0] UMAX = {bw_acc{1'b1}};

    logic               stall_s;
    logic [BW_PROD-1:0] prod_s [pr];

    logic               s1_valid_q, s1_signed_q, s1_first_q, s1_last_q;
    logic [BW_PROD-1:0] s1_prod_q [pr];
    logic [bw_acc-1:0]  sum_s;

    logic               s2_valid_q, s2_signed_q, s2_first_q, s2_last_q;
    logic [bw_acc-1:0]  s2_sum_q;

    logic [bw_acc-1:0]  base_s, clamped_s;
    logic [bw_acc:0]    wide_s;
    logic               clamp_s, sticky_s;

    logic [bw_acc-1:0]  acc_q, acc_d;
    logic               acc_sat_q, acc_sat_d;
    logic [bw_acc-1:0]  out_q, out_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;

    assign stall_s       = out_valid_q && !bus.out_ready;
    assign bus.in_ready  = !stall_s;
    assign bus.out       = out_q;
    assign bus.sat       = sat_q;
    assign bus.out_valid = out_valid_q;

    for (genvar i = 0; i < pr; i++) begin : g_lane
        mac_lane #(.bw(bw)) u_lane (
            .signed_mode_i (bus.signed_mode),
            .a_i           (bus.a[bw*i +: bw]),
            .b_i           (bus.b[bw*i +: bw]),
            .p_o           (prod_s[i])
        );
    end

    // Stage 1: capture lane products with the beat's control flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            for (int i = 0; i < pr; i++) begin
                s1_prod_q[i] <= '0;
            end
        end else if (!stall_s) begin
            s1_valid_q  <= bus.in_valid;
            s1_signed_q <= bus.signed_mode;
            s1_first_q  <= bus.acc_first;
            s1_last_q   <= bus.acc_last;
            for (int i = 0; i < pr; i++) begin
                s1_prod_q[i] <= prod_s[i];
            end
        end
    end

    // Lane reduction; the sum of pr products always fits in bw_psum bits.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < pr; i++) begin
            if (s1_signed_q) begin
                sum_s = sum_s + {{EXT_W{s1_prod_q[i][BW_PROD-1]}}, s1_prod_q[i]};
            end else begin
                sum_s = sum_s + {{EXT_W{1'b0}}, s1_prod_q[i]};
            end
        end
    end

    // Stage 2: hold the beat sum for the accumulator update.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_signed_q <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sum_q    <= '0;
        end else if (!stall_s) begin
            s2_valid_q  <= s1_valid_q;
            s2_signed_q <= s1_signed_q;
            s2_first_q  <= s1_first_q;
            s2_last_q   <= s1_last_q;
            s2_sum_q    <= sum_s;
        end
    end

    // One-bit-wider add, then clamp to the range implied by this beat's mode.
    always_comb begin
        base_s    = s2_first_q ? '0 : acc_q;
        wide_s    = {1'b0, base_s} + {1'b0, s2_sum_q};
        clamp_s   = 1'b0;
        clamped_s = wide_s[bw_acc-1:0];
        if (s2_signed_q) begin
            wide_s = {base_s[bw_acc-1], base_s} + {s2_sum_q[bw_acc-1], s2_sum_q};
            if (wide_s[bw_acc] != wide_s[bw_acc-1]) begin
                clamp_s   = 1'b1;
                clamped_s = wide_s[bw_acc] ? SMIN : SMAX;
            end else begin
                clamp_s   = 1'b0;
                clamped_s = wide_s[bw_acc-1:0];
            end
        end else begin
            if (wide_s[bw_acc]) begin
                clamp_s   = 1'b1;
                clamped_s = UMAX;
            end else begin
                clamp_s   = 1'b0;
                clamped_s = wide_s[bw_acc-1:0];
            end
        end
        sticky_s = (s2_first_q ? 1'b0 : acc_sat_q) | clamp_s;
    end

    // Accumulator and result register next state; everything holds under stall.
    always_comb begin
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        out_d       = out_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        if (!stall_s) begin
            if (s2_valid_q) begin
                acc_d     = clamped_s;
                acc_sat_d = sticky_s;
            end else begin
                acc_d     = acc_q;
                acc_sat_d = acc_sat_q;
            end
            if (s2_valid_q && s2_last_q) begin
                out_d       = clamped_s;
                sat_d       = sticky_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            acc_sat_q   <= 1'b0;
            out_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            out_q       <= out_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed and randomized checks of mac_acc_pipe against a group-level arithmetic model.
module tb_mac_acc_pipe;

    localparam int BW  = 8;
    localparam int PR  = 8;
    localparam int EXT = 4;
    localparam int W   = 2 * BW + $clog2(PR) + EXT;

    logic clk;
    logic reset;

    mac_acc_pipe_if #(.bw(BW), .pr(PR), .acc_ext(EXT)) bus_if ();

    mac_acc_pipe #(.bw(BW), .pr(PR), .acc_ext(EXT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    longint      m_acc = 0;
    bit          m_sat = 1'b0;
    longint      exp_out [$];
    bit          exp_sat [$];
    bit          acc_fire, hs_fire;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_out, prev_sat;
    logic [63:0] last_out, last_sat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_beat();
        longint sum, base, nxt, lo, hi;
        bit     clamp, sm;
        sm  = bus_if.signed_mode;
        sum = 0;
        for (int i = 0; i < PR; i++) begin
            logic [BW-1:0] av, bv;
            av = bus_if.a[BW*i +: BW];
            bv = bus_if.b[BW*i +: BW];
            if (sm) sum += longint'($signed(av)) * longint'($signed(bv));
            else    sum += longint'(av) * longint'(bv);
        end
        if (bus_if.acc_first)     base = 0;
        else if (sm && m_acc[W-1]) base = m_acc - (longint'(1) << W);
        else                      base = m_acc;
        nxt   = base + sum;
        lo    = sm ? -(longint'(1) << (W - 1)) : 0;
        hi    = sm ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
        clamp = 1'b0;
        if (nxt > hi) begin
            nxt = hi; clamp = 1'b1;
        end else if (nxt < lo) begin
            nxt = lo; clamp = 1'b1;
        end
        m_sat = (bus_if.acc_first ? 1'b0 : m_sat) | clamp;
        m_acc = nxt & ((longint'(1) << W) - 1);
        if (bus_if.acc_last) begin
            exp_out.push_back(m_acc);
            exp_sat.push_back(m_sat);
        end
    endtask

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        acc_fire = 1'b0;
        hs_fire  = 1'b0;
        if (reset) begin
            m_acc = 0;
            m_sat = 1'b0;
            exp_out.delete();
            exp_sat.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 64'(bus_if.in_ready), 64'(!(bus_if.out_valid && !bus_if.out_ready)));
            if (prev_stall) begin
                chk("hold_out", 64'(bus_if.out), prev_out);
                chk("hold_sat", 64'(bus_if.sat), prev_sat);
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                hs_fire  = 1'b1;
                last_out = 64'(bus_if.out);
                last_sat = 64'(bus_if.sat);
                if (exp_out.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    chk("out", last_out, 64'(exp_out.pop_front()));
                    chk("sat", last_sat, 64'(exp_sat.pop_front()));
                end
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                acc_fire = 1'b1;
                model_beat();
            end
            prev_stall = bus_if.out_valid && !bus_if.out_ready;
            prev_out   = 64'(bus_if.out);
            prev_sat   = 64'(bus_if.sat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PR*BW-1:0] av, input logic [PR*BW-1:0] bv,
                        input logic sm, input logic f, input logic l);
        bus_if.in_valid    = 1'b1;
        bus_if.a           = av;
        bus_if.b           = bv;
        bus_if.signed_mode = sm;
        bus_if.acc_first   = f;
        bus_if.acc_last    = l;
        for (int k = 0; k < 50; k++) begin
            step();
            if (acc_fire) break;
        end
        chk("send_timeout", 64'(acc_fire), 64'(1));
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_result();
        bus_if.in_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (hs_fire) break;
        end
        chk("result_timeout", 64'(hs_fire), 64'(1));
    endtask

    task automatic run_group(input int n, input logic [BW-1:0] av, input logic [BW-1:0] bv,
                             input logic sm);
        for (int k = 0; k < n; k++) begin
            send({PR{av}}, {PR{bv}}, sm, k == 0, k == n - 1);
        end
        wait_result();
    endtask

    initial begin
        reset              = 1'b1;
        bus_if.in_valid    = 1'b0;
        bus_if.a           = '0;
        bus_if.b           = '0;
        bus_if.signed_mode = 1'b0;
        bus_if.acc_first   = 1'b0;
        bus_if.acc_last    = 1'b0;
        bus_if.out_ready   = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_out", 64'(bus_if.out), 64'(0));
        chk("rst_sat", 64'(bus_if.sat), 64'(0));
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'(1));

        // Single signed beat and its two-edge latency.
        send({{(PR-1)*BW{1'b0}}, 8'hFD}, {{(PR-1)*BW{1'b0}}, 8'h05}, 1'b1, 1'b1, 1'b1);
        chk("lat_edge0", 64'(bus_if.out_valid), 64'(0));
        step();
        chk("lat_edge1", 64'(bus_if.out_valid), 64'(0));
        step();
        chk("lat_edge2", 64'(bus_if.out_valid), 64'(1));
        chk("single_out", 64'(bus_if.out), 64'h7FFFF1);
        chk("single_sat", 64'(bus_if.sat), 64'(0));
        wait_result();

        run_group(32, 8'h80, 8'h80, 1'b1);
        chk("s32_out", last_out, 64'd4194303);
        chk("s32_sat", last_sat, 64'd1);
        run_group(31, 8'h80, 8'h80, 1'b1);
        chk("s31_out", last_out, 64'd4063232);
        chk("s31_sat", last_sat, 64'd0);
        run_group(16, 8'hFF, 8'hFF, 1'b0);
        chk("u16_out", last_out, 64'd8323200);
        chk("u16_sat", last_sat, 64'd0);
        run_group(17, 8'hFF, 8'hFF, 1'b0);
        chk("u17_out", last_out, 64'd8388607);
        chk("u17_sat", last_sat, 64'd1);

        // Back-to-back one-beat groups right after a saturated group.
        for (int k = 1; k <= 3; k++) begin
            send({{(PR-1)*BW{1'b0}}, 8'h01}, 64'(k), 1'b1, 1'b1, 1'b1);
        end
        for (int k = 1; k <= 3; k++) begin
            chk("b2b_valid", 64'(bus_if.out_valid), 64'(1));
            chk("b2b_out", 64'(bus_if.out), 64'(k));
            chk("b2b_sat", 64'(bus_if.sat), 64'(0));
            step();
        end
        chk("b2b_idle", 64'(bus_if.out_valid), 64'(0));

        // Backpressure with a beat waiting at the input.
        bus_if.out_ready = 1'b0;
        send(64'h07, 64'h01, 1'b1, 1'b1, 1'b1);
        step();
        step();
        chk("bp_valid", 64'(bus_if.out_valid), 64'(1));
        bus_if.in_valid    = 1'b1;
        bus_if.a           = 64'h02;
        bus_if.b           = 64'h04;
        bus_if.signed_mode = 1'b0;
        bus_if.acc_first   = 1'b1;
        bus_if.acc_last    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_in_ready", 64'(bus_if.in_ready), 64'(0));
            chk("bp_out_held", 64'(bus_if.out), 64'd7);
        end
        bus_if.out_ready = 1'b1;
        step();
        chk("bp_release_hs", 64'(hs_fire), 64'(1));
        chk("bp_release_acc", 64'(acc_fire), 64'(1));
        wait_result();
        chk("bp_second_out", last_out, 64'd8);

        // Reset part-way through a group.
        for (int k = 0; k < 3; k++) begin
            send({PR{8'h11}}, {PR{8'h22}}, 1'b0, k == 0, 1'b0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_in_ready", 64'(bus_if.in_ready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_rst_no_valid", 64'(bus_if.out_valid), 64'(0));
        end
        send(64'h03, 64'h02, 1'b0, 1'b0, 1'b1);
        wait_result();
        chk("post_rst_out", last_out, 64'd6);

        // Randomized traffic, including occasional saturating operands and resets.
        for (int c = 0; c < 1500; c++) begin
            logic [PR*BW-1:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                ra = $urandom_range(0, 1) ? {PR{8'h80}} : {PR{8'hFF}};
                rb = ra;
            end
            bus_if.in_valid    = ($urandom_range(0, 3) != 0);
            bus_if.a           = ra;
            bus_if.b           = rb;
            bus_if.signed_mode = 1'($urandom_range(0, 1));
            bus_if.acc_first   = ($urandom_range(0, 3) == 0);
            bus_if.acc_last    = ($urandom_range(0, 3) == 0);
            bus_if.out_ready   = ($urandom_range(0, 3) != 0);
            reset              = ($urandom_range(0, 199) == 0);
            step();
        end
        reset            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (exp_out.size() == 0) break;
            step();
        end
        chk("drain_pending", 64'(exp_out.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_acc_pipe.md
MAC_ACC_PIPE -- requirements
Module: mac_acc_pipe

Interface
REQ-001 SHALL have parameter bw, default 8: operand element width.
REQ-002 SHALL have parameter pr, default 8: lane count, a power of two with pr >= 2.
REQ-003 SHALL have parameter acc_ext, default 4: accumulator guard bits.
REQ-004 SHALL derive bw_psum = 2*bw+$clog2(pr) (19 at defaults) and bw_acc = bw_psum+acc_ext (23 at defaults).
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 in_valid  in  1  beat offered.
REQ-008 in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-009 a  in  pr*bw  lane i at bits [bw*(i+1)-1 : bw*i].
REQ-010 b  in  pr*bw  same packing as a.
REQ-011 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled per beat.
REQ-012 acc_first  in  1  beat starts a new accumulation group.
REQ-013 acc_last  in  1  beat ends the group; may be set together with acc_first.
REQ-014 out  out  bw_acc  final group result.
REQ-015 sat  out  1  group saturated at least once.
REQ-016 out_valid  out  1  out and sat are valid.
REQ-017 out_ready  in  1  consumer accepts when out_valid && out_ready.

Function
REQ-018 SHALL be a two-stage pipeline: S1 registers pr lane products; S2 adds the products and updates the accumulator.
REQ-019 SHALL, per lane, sign-extend (signed_mode=1) or zero-extend (signed_mode=0) each operand to 2*bw bits, multiply, and extend the product to bw_acc bits.
REQ-020 SHALL carry signed_mode, acc_first and acc_last alongside each beat through both stages.
REQ-021 SHALL, in S2, form acc_next = sum if acc_first, else acc + sum, computed at bw_acc+1 bits.
REQ-022 SHALL clamp acc_next on overflow: signed range [-2^(bw_acc-1), 2^(bw_acc-1)-1]; unsigned range [0, 2^bw_acc-1].
REQ-023 SHALL hold the clamped value as the accumulator and continue accumulating from it.
REQ-024 SHALL set sat whenever clamping occurs in the group; sat is sticky and is cleared only by an acc_first beat or by reset.
REQ-025 SHALL, when an acc_last beat leaves S2, register out and sat and assert out_valid on the next edge: accepted at edge N, out_valid high after edge N+2.
REQ-026 SHALL use a global stall stall = out_valid && !out_ready that freezes S1, S2, the accumulator and the output registers.
REQ-027 SHALL drive in_ready = !stall combinationally.
REQ-028 SHALL hold out and sat stable while out_valid && !out_ready.
REQ-029 SHALL, on an out handshake in the same cycle as a new acc_last beat completes, present the new result back-to-back with no bubble.
REQ-030 SHALL propagate bubbles (in_valid=0) without changing the accumulator.
REQ-031 SHALL treat a beat in a group with acc_first=0 and no prior group start as accumulating onto the current accumulator contents.

Reset
REQ-032 Reset SHALL clear out=0, sat=0, out_valid=0, both stage valid flags and the accumulator on the next edge.
REQ-033 Reset SHALL drop any in-flight beats, including during a stall.
REQ-034 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-035 SHALL take the default bw, pr and acc_ext values and the bw_psum/bw_acc width functions from a shared package mac_pkg.
REQ-036 SHALL instantiate pr copies of one sub-module, mac_lane: a combinational signed/unsigned bw x bw multiplier with a 2*bw-bit result.

Verification
REQ-037 Single beat, signed: lane0 a=-3, b=5, all other lanes 0, acc_first=acc_last=1 -> out=-15 (0x7FFFF1), sat=0, out_valid 2 edges after acceptance.
REQ-038 Signed saturation: 32 beats, all lanes a=b=-128 -> out=4194303, sat=1; the same test with 31 beats -> out=4063232, sat=0.
REQ-039 Unsigned saturation: signed_mode=0, all lanes a=b=255; 16 beats -> out=8323200, sat=0; 17 beats -> out=8388607, sat=1.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles with result pending -> in_ready=0, out held stable, no beat lost; a subsequent 1-beat group of sum 8 yields out=8.
REQ-041 Back-to-back groups with out_ready=1: 1-beat groups summing 1, 2, 3 -> out_valid high on 3 consecutive cycles with out=1, 2, 3; sat cleared by acc_first after a saturating group.
REQ-042 Reset mid-group after 3 beats accepted -> no out_valid; a fresh group then produces only its own sum.
